// File: rtl/irq_controller.sv
// Interrupt controller: latches source rising edges into PEND, masks and
// prioritises them (index 0 highest), and sequences one interrupt at a time
// through IDLE -> REQ (irq high) -> SERVICE (until EOI write).
module irq_controller #(
  parameter int          NSRC      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic            int_take,
  output logic            irq,
  output logic [2:0]      active_id
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

  state_t          state;
  logic [NSRC-1:0] src_d;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic            gen;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] take_clr;
  logic [2:0]      winner;
  logic            take_fire;
  logic            sel_pend, sel_mask, sel_ctrl, sel_cause;
  logic            eoi_wr;

  // addr[1:0] and data bits above the source count carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};

  assign sel_pend  = (addr[31:2] == BASE_W);
  assign sel_mask  = (addr[31:2] == BASE_W + 30'd1);
  assign sel_ctrl  = (addr[31:2] == BASE_W + 30'd2);
  assign sel_cause = (addr[31:2] == BASE_W + 30'd3);
  assign eoi_wr    = wr && (addr[31:2] == BASE_W + 30'd4);

  assign rise = src & ~src_d;
  assign elig = pend & mask & {NSRC{gen}};
  assign w1c  = (wr && sel_pend) ? wdata[NSRC-1:0] : '0;

  // A take with nothing eligible still enters SERVICE but clears no bit
  assign take_fire = (state == REQ) && int_take && (|elig);

  // Priority pick: lowest eligible index wins, 0 when nothing is eligible
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) winner = 3'(i);
    end
  end

  // One-hot clear of the pending bit being taken into service
  always_comb begin
    take_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      take_clr[i] = take_fire && (winner == 3'(i));
    end
  end

  // Combinational register read-back, zero when not reading
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_pend)       rdata = 32'(pend);
      else if (sel_mask)  rdata = 32'(mask);
      else if (sel_ctrl)  rdata = {31'b0, gen};
      else if (sel_cause) rdata = {(state == SERVICE), 28'b0, active_id};
    end
  end

  // Edge capture into PEND; a new edge beats any clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_d <= '0;
      pend  <= '0;
    end else begin
      src_d <= src;
      pend  <= (pend & ~w1c & ~take_clr) | rise;
    end
  end

  // Software-writable MASK and global enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      gen  <= 1'b0;
    end else if (wr) begin
      if (sel_mask) mask <= wdata[NSRC-1:0];
      if (sel_ctrl) gen  <= wdata[0];
    end
  end

  // Request/service sequencer with registered irq and active_id
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      irq       <= 1'b0;
      active_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|elig) begin
            state <= REQ;
            irq   <= 1'b1;
          end
        end
        REQ: begin
          if (int_take) begin
            state     <= SERVICE;
            irq       <= 1'b0;
            active_id <= winner;
          end else if (!(|elig)) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi_wr) begin
            state     <= IDLE;
            active_id <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          irq       <= 1'b0;
          active_id <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: table of register-access vectors followed by
// hand-written multi-cycle sequences (edge capture, priority, take, EOI,
// W1C races, stray take, asynchronous reset).
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h40000030;
  localparam logic [7:0]  O_PEND = 8'h00, O_MASK = 8'h04, O_CTRL = 8'h08,
                          O_CAUSE = 8'h0C, O_EOI = 8'h10, O_BAD = 8'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        int_take;
  logic        irq;
  logic [2:0]  active_id;

  int total  = 0;
  int passed = 0;

  irq_controller #(.NSRC(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .src(src), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .int_take(int_take), .irq(irq),
    .active_id(active_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
    addr = BASE + 32'(off); wdata = d; wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    addr = BASE + 32'(off); rd = 1'b1;
    #1;
    chk(name, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic pulse_src(input logic [3:0] s);
    src = s;
    step();
    src = 4'b0;
  endtask

  task automatic take();
    int_take = 1'b1;
    step();
    int_take = 1'b0;
  endtask

  initial begin
    // wr, rd, off, wdata, exp_rdata, exp_irq
    vecs[0]  = '{1'b0, 1'b1, O_PEND,  32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b1, O_MASK,  32'h0,        32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b1, O_CTRL,  32'h0,        32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b1, O_CAUSE, 32'h0,        32'h0,        1'b0};
    vecs[4]  = '{1'b1, 1'b0, O_MASK,  32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 1'b1, O_MASK,  32'h0,        32'h0000000F, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, O_MASK,  32'h0,        32'h0,        1'b0};
    vecs[7]  = '{1'b1, 1'b0, O_CTRL,  32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 1'b1, O_CTRL,  32'h0,        32'h00000001, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, O_EOI,   32'h0,        32'h0,        1'b0};
    vecs[10] = '{1'b1, 1'b0, O_BAD,   32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 1'b1, O_BAD,   32'h0,        32'h0,        1'b0};
    vecs[12] = '{1'b0, 1'b1, O_MASK,  32'h0,        32'h0000000F, 1'b0};
    vecs[13] = '{1'b1, 1'b0, O_MASK,  32'h00000005, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 1'b1, O_MASK,  32'h0,        32'h00000005, 1'b0};

    reset = 1'b1; src = '0; rd = 0; wr = 0; addr = '0; wdata = '0; int_take = 0;
    step(); step();
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_active_id", 32'(active_id), 32'h0);
    chk("reset_rdata_idle", rdata, 32'h0);
    reset = 1'b0;
    step();

    // Register access table
    for (int i = 0; i < 15; i++) begin
      addr = BASE + 32'(vecs[i].off);
      wr = vecs[i].wr; rd = vecs[i].rd; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      step();
      wr = 1'b0; rd = 1'b0;
    end

    // Basic single-source flow
    bus_wr(O_MASK, 32'h1);
    bus_wr(O_CTRL, 32'h1);
    pulse_src(4'b0001);
    rd_chk("s1_pend_set", O_PEND, 32'h1);
    chk("s1_irq_not_yet", 32'(irq), 32'h0);
    step();
    chk("s1_irq_up", 32'(irq), 32'h1);
    take();
    chk("s1_irq_after_take", 32'(irq), 32'h0);
    rd_chk("s1_cause", O_CAUSE, 32'h80000000);
    rd_chk("s1_pend_cleared", O_PEND, 32'h0);
    bus_wr(O_EOI, 32'h0);
    rd_chk("s1_cause_after_eoi", O_CAUSE, 32'h0);

    // Priority between two simultaneous sources
    bus_wr(O_MASK, 32'hF);
    pulse_src(4'b1010);
    step();
    chk("s2_irq_up", 32'(irq), 32'h1);
    take();
    chk("s2_active_id_1", 32'(active_id), 32'h1);
    rd_chk("s2_pend_left", O_PEND, 32'h8);
    rd_chk("s2_cause", O_CAUSE, 32'h80000001);
    bus_wr(O_EOI, 32'h0);
    chk("s2_irq_low_after_eoi", 32'(irq), 32'h0);
    step();
    chk("s2_irq_reasserts", 32'(irq), 32'h1);
    take();
    chk("s2_active_id_3", 32'(active_id), 32'h3);
    rd_chk("s2_pend_empty", O_PEND, 32'h0);
    bus_wr(O_EOI, 32'h0);

    // Masked source: pending but no request until unmasked
    bus_wr(O_MASK, 32'h0);
    pulse_src(4'b0100);
    step(); step();
    rd_chk("s3_pend", O_PEND, 32'h4);
    chk("s3_irq_masked", 32'(irq), 32'h0);
    bus_wr(O_MASK, 32'h4);
    chk("s3_irq_same_cycle", 32'(irq), 32'h0);
    step();
    chk("s3_irq_after_unmask", 32'(irq), 32'h1);
    bus_wr(O_EOI, 32'h0);
    chk("s3_eoi_in_req_ignored", 32'(irq), 32'h1);

    // W1C drops the request; set beats a coincident clear
    bus_wr(O_PEND, 32'hF);
    step();
    chk("s4_irq_dropped", 32'(irq), 32'h0);
    rd_chk("s4_pend_clear", O_PEND, 32'h0);
    rd_chk("s4_cause_idle", O_CAUSE, 32'h0);
    src = 4'b0001;
    bus_wr(O_PEND, 32'h1);
    src = 4'b0000;
    rd_chk("s4_set_wins", O_PEND, 32'h1);
    bus_wr(O_PEND, 32'h1);
    rd_chk("s4_w1c_after", O_PEND, 32'h0);

    // Activity during SERVICE, stray take, reset mid-service
    bus_wr(O_MASK, 32'h1);
    pulse_src(4'b0001);
    step();
    take();
    pulse_src(4'b0001);
    step(); step();
    chk("s5_no_nesting_irq", 32'(irq), 32'h0);
    rd_chk("s5_pend_accum", O_PEND, 32'h1);
    take();
    rd_chk("s5_stray_take_cause", O_CAUSE, 32'h80000000);
    rd_chk("s5_stray_take_pend", O_PEND, 32'h1);
    chk("s5_stray_take_irq", 32'(irq), 32'h0);
    reset = 1'b1;
    #1;
    rd_chk("s5_reset_cause", O_CAUSE, 32'h0);
    rd_chk("s5_reset_pend", O_PEND, 32'h0);
    rd_chk("s5_reset_mask", O_MASK, 32'h0);
    rd_chk("s5_reset_ctrl", O_CTRL, 32'h0);
    chk("s5_reset_active_id", 32'(active_id), 32'h0);
    step();
    reset = 1'b0;

    // Asynchronous reset drops irq mid-cycle while in REQ
    bus_wr(O_MASK, 32'h2);
    bus_wr(O_CTRL, 32'h1);
    pulse_src(4'b0010);
    step();
    chk("s6_irq_up", 32'(irq), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("s6_async_reset_irq", 32'(irq), 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("s6_stays_idle", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
